// File: rtl/csr_trap_sequencer_pkg.sv
// Shared CSR layouts, numbers and trap sequencer types.
// Imported by the trap sequencer and its interrupt arbiter.
package csr_trap_sequencer_pkg;

  localparam int DataPath = 32;
  localparam int CsrNumPath = 12;
  localparam int CSR_CAUSE_CodePath = 5;

  localparam logic [CsrNumPath-1:0] CSR_NUM_MSTATUS = 12'h300;
  localparam logic [CsrNumPath-1:0] CSR_NUM_MIE = 12'h304;
  localparam logic [CsrNumPath-1:0] CSR_NUM_MTVEC = 12'h305;
  localparam logic [CsrNumPath-1:0] CSR_NUM_MEPC = 12'h341;
  localparam logic [CsrNumPath-1:0] CSR_NUM_MCAUSE = 12'h342;
  localparam logic [CsrNumPath-1:0] CSR_NUM_MTVAL = 12'h343;
  localparam logic [CsrNumPath-1:0] CSR_NUM_MIP = 12'h344;

  localparam int MSTATUS_MIE_BIT = 3;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  typedef enum logic [CSR_CAUSE_CodePath-1:0] {
    CSR_CAUSE_INTERRUPT_CODE_NONE = 5'd0,
    CSR_CAUSE_INTERRUPT_CODE_SOFTWARE = 5'd3,
    CSR_CAUSE_INTERRUPT_CODE_TIMER = 5'd7,
    CSR_CAUSE_INTERRUPT_CODE_EXTERNAL = 5'd11
  } CSR_CAUSE_InterruptCodePath;

  typedef struct packed {
    logic [23:0] wpri_hi;
    logic mpie;
    logic [2:0] wpri_mid;
    logic mie;
    logic [2:0] wpri_lo;
  } CSR_MSTATUS;

  typedef struct packed {
    logic [19:0] rsvd3;
    logic meip;
    logic [2:0] rsvd2;
    logic mtip;
    logic [2:0] rsvd1;
    logic msip;
    logic [2:0] rsvd0;
  } CSR_MIP;

  typedef struct packed {
    logic [19:0] rsvd3;
    logic meie;
    logic [2:0] rsvd2;
    logic mtie;
    logic [2:0] rsvd1;
    logic msie;
    logic [2:0] rsvd0;
  } CSR_MIE;

  typedef struct packed {
    logic [29:0] base;
    logic [1:0] mode;
  } CSR_MTVEC;

  typedef struct packed {
    logic is_interrupt;
    logic [25:0] zero;
    logic [CSR_CAUSE_CodePath-1:0] code;
  } CSR_CAUSE;

  typedef enum logic [2:0] {
    IDLE,
    WR_MEPC,
    WR_MCAUSE,
    WR_MTVAL,
    WR_MSTATUS,
    REDIRECT
  } TrapSeqStatePath;

  function automatic CSR_MSTATUS mstatus_on_trap(
    input CSR_MSTATUS s
  );
    CSR_MSTATUS r;
    r = s;
    r.mpie = s.mie;
    r.mie = 1'b0;
    return r;
  endfunction

  function automatic CSR_MSTATUS mstatus_on_mret(
    input CSR_MSTATUS s
  );
    CSR_MSTATUS r;
    r = s;
    r.mie = s.mpie;
    r.mpie = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/csr_interrupt_arbiter.sv
// Fixed-priority machine interrupt selector.
// External beats software, software beats timer.
module csr_interrupt_arbiter
  import csr_trap_sequencer_pkg::*;
(
  input  logic global_mie,
  input  CSR_MIP mip,
  input  CSR_MIE mie,
  output logic pending,
  output logic [CSR_CAUSE_CodePath-1:0] code
);

  logic c_ext;
  logic c_sw;
  logic c_tim;
  logic [2:0] grant;
  logic unused_ok;

  assign c_ext = global_mie & mip.meip & mie.meie;
  assign c_sw = global_mie & mip.msip & mie.msie;
  assign c_tim = global_mie & mip.mtip & mie.mtie;

  assign grant = {c_ext, c_sw & ~c_ext, c_tim & ~c_ext & ~c_sw};
  assign pending = |grant;

  always_comb begin
    code = CSR_CAUSE_INTERRUPT_CODE_NONE;
    unique case (1'b1)
      grant[2]: code = CSR_CAUSE_INTERRUPT_CODE_EXTERNAL;
      grant[1]: code = CSR_CAUSE_INTERRUPT_CODE_SOFTWARE;
      grant[0]: code = CSR_CAUSE_INTERRUPT_CODE_TIMER;
      default: code = CSR_CAUSE_INTERRUPT_CODE_NONE;
    endcase
  end

  assign unused_ok = ^{mip.rsvd3, mip.rsvd2, mip.rsvd1,
                       mip.rsvd0, mie.rsvd3, mie.rsvd2,
                       mie.rsvd1, mie.rsvd0};

endmodule

// File: rtl/csr_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: one CSR write
// per cycle, then a valid/ready redirect to fetch.
module csr_trap_sequencer
  import csr_trap_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic trapReq,
  input  logic trapIsInterrupt,
  input  logic [CSR_CAUSE_CodePath-1:0] trapCode,
  input  logic [DataPath-1:0] trapPC,
  input  logic [DataPath-1:0] trapTval,
  input  logic mretReq,
  input  logic [DataPath-1:0] mstatus,
  input  logic [DataPath-1:0] mie,
  input  logic [DataPath-1:0] mip,
  input  logic [DataPath-1:0] mtvec,
  input  logic [DataPath-1:0] mepc,
  output logic csrWE,
  output logic [CsrNumPath-1:0] csrWriteNum,
  output logic [DataPath-1:0] csrWriteData,
  output logic irqPending,
  output logic [CSR_CAUSE_CodePath-1:0] irqCode,
  output logic busy,
  output logic redirectValid,
  output logic [DataPath-1:0] redirectPC,
  input  logic redirectReady
);

  TrapSeqStatePath state;
  logic cap_int;
  logic [CSR_CAUSE_CodePath-1:0] cap_code;
  logic [DataPath-1:0] cap_tval;
  CSR_MSTATUS cap_mstatus;
  CSR_MTVEC cap_mtvec;
  logic [DataPath-1:0] cap_mepc;
  logic is_mret;
  logic arb_pending;
  logic [DataPath-1:0] target;
  CSR_CAUSE cause;
  logic unused_ok;

  csr_interrupt_arbiter u_arb (
    .global_mie(mstatus[MSTATUS_MIE_BIT]),
    .mip(mip),
    .mie(mie),
    .pending(arb_pending),
    .code(irqCode)
  );

  assign irqPending = arb_pending & (state == IDLE);
  assign busy = (state != IDLE);
  assign cause = {cap_int, 26'd0, cap_code};
  assign unused_ok = ^trapPC[1:0];

  // Vectored offset applies to interrupts only.
  always_comb begin
    target = {cap_mtvec.base, 2'b00};
    if (is_mret)
      target = cap_mepc;
    else if (cap_mtvec.mode == MTVEC_MODE_VECTORED && cap_int)
      target = {cap_mtvec.base, 2'b00}
             + {25'd0, cap_code, 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cap_int <= 1'b0;
      cap_code <= '0;
      cap_tval <= '0;
      cap_mstatus <= '0;
      cap_mtvec <= '0;
      cap_mepc <= '0;
      is_mret <= 1'b0;
      csrWE <= 1'b0;
      csrWriteNum <= '0;
      csrWriteData <= '0;
      redirectValid <= 1'b0;
      redirectPC <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (trapReq) begin
            state <= WR_MEPC;
            cap_int <= trapIsInterrupt;
            cap_code <= trapCode;
            cap_tval <= trapIsInterrupt ? '0 : trapTval;
            cap_mstatus <= mstatus;
            cap_mtvec <= mtvec;
            csrWE <= 1'b1;
            csrWriteNum <= CSR_NUM_MEPC;
            csrWriteData <= {trapPC[31:2], 2'b00};
          end else if (mretReq) begin
            state <= WR_MSTATUS;
            is_mret <= 1'b1;
            cap_mstatus <= mstatus;
            cap_mepc <= mepc;
            csrWE <= 1'b1;
            csrWriteNum <= CSR_NUM_MSTATUS;
            csrWriteData <= mstatus_on_mret(mstatus);
          end
        end
        WR_MEPC: begin
          state <= WR_MCAUSE;
          csrWriteNum <= CSR_NUM_MCAUSE;
          csrWriteData <= cause;
        end
        WR_MCAUSE: begin
          state <= WR_MTVAL;
          csrWriteNum <= CSR_NUM_MTVAL;
          csrWriteData <= cap_tval;
        end
        WR_MTVAL: begin
          state <= WR_MSTATUS;
          csrWriteNum <= CSR_NUM_MSTATUS;
          csrWriteData <= mstatus_on_trap(cap_mstatus);
        end
        WR_MSTATUS: begin
          state <= REDIRECT;
          csrWE <= 1'b0;
          csrWriteNum <= '0;
          csrWriteData <= '0;
          redirectValid <= 1'b1;
          redirectPC <= target;
        end
        REDIRECT: begin
          if (redirectReady) begin
            state <= IDLE;
            redirectValid <= 1'b0;
            is_mret <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
